// File: rtl/bus_dev_port.sv
// Device endpoint for one slot of the bus generator/arbiter: a first-word
// fall-through TX FIFO toward the arbiter, an RX FIFO from it, and sticky error flags.
module bus_dev_port #(
  parameter int         width     = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_wr,
  input  logic [width-1:0]             tx_data,
  output logic                         tx_full,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic                         pndng,
  output logic [width-1:0]             D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [width-1:0]             D_push,
  input  logic                         rx_rd,
  output logic [width-1:0]             rx_data,
  output logic                         rx_valid,
  output logic                         rx_full,
  output logic                         tx_ovf,
  output logic                         tx_udf,
  output logic                         rx_ovf,
  output logic                         misroute,
  input  logic                         clr_flags
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  // ---------------- TX FIFO state ----------------
  logic [width-1:0] tx_mem_r [depth];
  logic [AW-1:0]    tx_wr_ptr_r;
  logic [AW-1:0]    tx_rd_ptr_r;
  logic [CW-1:0]    tx_count_r;
  logic             tx_full_r;
  logic             tx_nempty_r;
  logic             tx_pop_ok_s;
  logic             tx_wr_ok_s;
  logic [CW-1:0]    tx_count_next_s;

  // ---------------- RX FIFO state ----------------
  logic [width-1:0] rx_mem_r [depth];
  logic [AW-1:0]    rx_wr_ptr_r;
  logic [AW-1:0]    rx_rd_ptr_r;
  logic [CW-1:0]    rx_count_r;
  logic             rx_full_r;
  logic             rx_nempty_r;
  logic             rx_rd_ok_s;
  logic             rx_push_ok_s;
  logic [CW-1:0]    rx_count_next_s;

  // ---------------- flags ----------------
  logic             tx_ovf_r;
  logic             tx_udf_r;
  logic             rx_ovf_r;
  logic             misroute_r;
  logic             tx_ovf_ev_s;
  logic             tx_udf_ev_s;
  logic             rx_ovf_ev_s;
  logic             misroute_ev_s;
  logic [7:0]       push_dest_s;

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign tx_pop_ok_s     = pop & tx_nempty_r;
  assign tx_wr_ok_s      = tx_wr & (~tx_full_r | tx_pop_ok_s);
  assign tx_count_next_s = tx_count_r + CW'(tx_wr_ok_s) - CW'(tx_pop_ok_s);

  assign rx_rd_ok_s      = rx_rd & rx_nempty_r;
  assign rx_push_ok_s    = push & (~rx_full_r | rx_rd_ok_s);
  assign rx_count_next_s = rx_count_r + CW'(rx_push_ok_s) - CW'(rx_rd_ok_s);

  assign push_dest_s     = D_push[width-1:width-8];
  assign tx_ovf_ev_s     = tx_wr & tx_full_r & ~pop;
  assign tx_udf_ev_s     = pop & ~tx_nempty_r;
  assign rx_ovf_ev_s     = push & rx_full_r & ~rx_rd;
  assign misroute_ev_s   = push & (push_dest_s != id) & (push_dest_s != broadcast);

  // TX pointers, occupancy and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_r <= {AW{1'b0}};
      tx_rd_ptr_r <= {AW{1'b0}};
      tx_count_r  <= {CW{1'b0}};
      tx_full_r   <= 1'b0;
      tx_nempty_r <= 1'b0;
    end else begin
      if (tx_wr_ok_s) begin
        tx_wr_ptr_r <= tx_wr_ptr_r + AW'(1);
      end
      if (tx_pop_ok_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + AW'(1);
      end
      tx_count_r  <= tx_count_next_s;
      tx_full_r   <= (tx_count_next_s == CW'(depth));
      tx_nempty_r <= (tx_count_next_s != {CW{1'b0}});
    end
  end

  // TX storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (tx_wr_ok_s && !reset) begin
      tx_mem_r[tx_wr_ptr_r] <= tx_data;
    end
  end

  // RX pointers, occupancy and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_r <= {AW{1'b0}};
      rx_rd_ptr_r <= {AW{1'b0}};
      rx_count_r  <= {CW{1'b0}};
      rx_full_r   <= 1'b0;
      rx_nempty_r <= 1'b0;
    end else begin
      if (rx_push_ok_s) begin
        rx_wr_ptr_r <= rx_wr_ptr_r + AW'(1);
      end
      if (rx_rd_ok_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + AW'(1);
      end
      rx_count_r  <= rx_count_next_s;
      rx_full_r   <= (rx_count_next_s == CW'(depth));
      rx_nempty_r <= (rx_count_next_s != {CW{1'b0}});
    end
  end

  // RX storage
  always_ff @(posedge clk) begin
    if (rx_push_ok_s && !reset) begin
      rx_mem_r[rx_wr_ptr_r] <= D_push;
    end
  end

  // Sticky flags: a same-cycle event overrides clr_flags
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_r   <= 1'b0;
      tx_udf_r   <= 1'b0;
      rx_ovf_r   <= 1'b0;
      misroute_r <= 1'b0;
    end else begin
      tx_ovf_r   <= tx_ovf_ev_s   | (tx_ovf_r   & ~clr_flags);
      tx_udf_r   <= tx_udf_ev_s   | (tx_udf_r   & ~clr_flags);
      rx_ovf_r   <= rx_ovf_ev_s   | (rx_ovf_r   & ~clr_flags);
      misroute_r <= misroute_ev_s | (misroute_r & ~clr_flags);
    end
  end

  // Heads come straight from memory; registered non-empty bits zero them when empty.
  assign D_pop    = tx_nempty_r ? tx_mem_r[tx_rd_ptr_r] : {width{1'b0}};
  assign rx_data  = rx_nempty_r ? rx_mem_r[rx_rd_ptr_r] : {width{1'b0}};
  assign pndng    = tx_nempty_r;
  assign tx_full  = tx_full_r;
  assign tx_count = tx_count_r;
  assign rx_valid = rx_nempty_r;
  assign rx_full  = rx_full_r;
  assign tx_ovf   = tx_ovf_r;
  assign tx_udf   = tx_udf_r;
  assign rx_ovf   = rx_ovf_r;
  assign misroute = misroute_r;

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed bench for bus_dev_port: queue-based reference model checked every cycle,
// plus literal expectations at the test-plan checkpoints.
module tb_bus_dev_port;

  localparam int         W     = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h02;
  localparam logic [7:0] BC    = 8'hFF;

  logic          clk = 1'b0;
  logic          reset, tx_wr, pop, push, rx_rd, clr_flags;
  logic [W-1:0]  tx_data, D_push;
  logic          tx_full, pndng, rx_valid, rx_full;
  logic [3:0]    tx_count;
  logic [W-1:0]  D_pop, rx_data;
  logic          tx_ovf, tx_udf, rx_ovf, misroute;

  bus_dev_port #(.width(W), .depth(DEPTH), .id(ID), .broadcast(BC)) dut (
    .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_full(tx_full), .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .tx_ovf(tx_ovf), .tx_udf(tx_udf), .rx_ovf(rx_ovf), .misroute(misroute),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  bit m_tx_ovf, m_tx_udf, m_rx_ovf, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge applied to the queues and flags
  task automatic model_step(input bit rst, input bit wr, input logic [W-1:0] wd,
                            input bit pp, input bit ps, input logic [W-1:0] pd,
                            input bit rd, input bit clr);
    bit txe, txf, rxe, rxf, e_tovf, e_tudf, e_rovf, e_mis;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_tx_ovf = 0; m_tx_udf = 0; m_rx_ovf = 0; m_mis = 0;
    end else begin
      txe = (txq.size() == 0); txf = (txq.size() == DEPTH);
      rxe = (rxq.size() == 0); rxf = (rxq.size() == DEPTH);
      e_tudf = pp && txe;
      e_tovf = wr && txf && !pp;
      e_rovf = ps && rxf && !rd;
      e_mis  = ps && (pd[15:8] != ID) && (pd[15:8] != BC);
      if (pp && !txe) void'(txq.pop_front());
      if (wr && !e_tovf) txq.push_back(wd);
      if (rd && !rxe) void'(rxq.pop_front());
      if (ps && !e_rovf) rxq.push_back(pd);
      m_tx_ovf = e_tovf || (m_tx_ovf && !clr);
      m_tx_udf = e_tudf || (m_tx_udf && !clr);
      m_rx_ovf = e_rovf || (m_rx_ovf && !clr);
      m_mis    = e_mis  || (m_mis    && !clr);
    end
  endtask

  task automatic cyc(input bit rst, input bit wr, input logic [W-1:0] wd,
                     input bit pp, input bit ps, input logic [W-1:0] pd,
                     input bit rd, input bit clr);
    reset = rst; tx_wr = wr; tx_data = wd; pop = pp;
    push = ps; D_push = pd; rx_rd = rd; clr_flags = clr;
    @(posedge clk);
    #1;
    model_step(rst, wr, wd, pp, ps, pd, rd, clr);
    chk_en = 1'b1;
    reset = 1'b0; tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
  endtask

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        chk("pndng",    {31'd0, pndng},    {31'd0, txq.size() != 0});
        chk("tx_count", {28'd0, tx_count}, txq.size());
        chk("tx_full",  {31'd0, tx_full},  {31'd0, txq.size() == DEPTH});
        chk("D_pop",    {16'd0, D_pop},    {16'd0, (txq.size() != 0) ? txq[0] : 16'h0000});
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, rxq.size() != 0});
        chk("rx_full",  {31'd0, rx_full},  {31'd0, rxq.size() == DEPTH});
        chk("rx_data",  {16'd0, rx_data},  {16'd0, (rxq.size() != 0) ? rxq[0] : 16'h0000});
        chk("tx_ovf",   {31'd0, tx_ovf},   {31'd0, m_tx_ovf});
        chk("tx_udf",   {31'd0, tx_udf},   {31'd0, m_tx_udf});
        chk("rx_ovf",   {31'd0, rx_ovf},   {31'd0, m_rx_ovf});
        chk("misroute", {31'd0, misroute}, {31'd0, m_mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tx_wr = 1'b0; tx_data = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; rx_rd = 1'b0; clr_flags = 1'b0;

    // Reset held two cycles with writes pending
    cyc(1, 1, 16'h0311, 0, 1, 16'h02AA, 0, 0);
    cyc(1, 1, 16'h0311, 0, 1, 16'h02AA, 0, 0);
    idle();
    chk("rst_pndng", {31'd0, pndng}, 32'd0);
    chk("rst_count", {28'd0, tx_count}, 32'd0);
    chk("rst_dpop", {16'd0, D_pop}, 32'h0000);
    chk("rst_flags", {28'd0, tx_ovf, tx_udf, rx_ovf, misroute}, 32'd0);
    chk("rst_rxvalid", {31'd0, rx_valid}, 32'd0);

    // TX ordering
    cyc(0, 1, 16'h0311, 0, 0, 16'h0000, 0, 0);
    chk("ord_pndng1", {31'd0, pndng}, 32'd1);
    cyc(0, 1, 16'h0422, 0, 0, 16'h0000, 0, 0);
    cyc(0, 1, 16'h0533, 0, 0, 16'h0000, 0, 0);
    chk("ord_head0", {16'd0, D_pop}, 32'h0311);
    chk("ord_count3", {28'd0, tx_count}, 32'd3);
    cyc(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    chk("ord_head1", {16'd0, D_pop}, 32'h0422);
    cyc(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    chk("ord_head2", {16'd0, D_pop}, 32'h0533);
    cyc(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    chk("ord_empty", {31'd0, pndng}, 32'd0);
    chk("ord_udf", {31'd0, tx_udf}, 32'd0);

    // TX fill past depth, then simultaneous write/pop while full
    for (int i = 0; i < 9; i++) cyc(0, 1, 16'(16'h0100 + i), 0, 0, 16'h0000, 0, 0);
    chk("full_count", {28'd0, tx_count}, 32'd8);
    chk("full_flag", {31'd0, tx_full}, 32'd1);
    chk("full_ovf", {31'd0, tx_ovf}, 32'd1);
    cyc(0, 1, 16'h01EE, 1, 0, 16'h0000, 0, 0);
    chk("wp_count", {28'd0, tx_count}, 32'd8);
    chk("wp_head", {16'd0, D_pop}, 32'h0101);
    chk("wp_ovf", {31'd0, tx_ovf}, 32'd1);
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
    chk("clr_ovf", {31'd0, tx_ovf}, 32'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    chk("wrap_tail", {16'd0, D_pop}, 32'h01EE);
    cyc(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    chk("drain_pndng", {31'd0, pndng}, 32'd0);

    // Underflow with a same-cycle write
    cyc(0, 1, 16'h01AB, 1, 0, 16'h0000, 0, 0);
    chk("udf_flag", {31'd0, tx_udf}, 32'd1);
    chk("udf_count", {28'd0, tx_count}, 32'd1);
    chk("udf_head", {16'd0, D_pop}, 32'h01AB);
    cyc(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
    chk("clr_vs_event", {31'd0, tx_udf}, 32'd1);
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
    chk("clr_udf", {31'd0, tx_udf}, 32'd0);

    // RX routing
    cyc(0, 0, 16'h0000, 0, 1, 16'hFFAA, 0, 0);
    chk("rt_bcast", {31'd0, misroute}, 32'd0);
    cyc(0, 0, 16'h0000, 0, 1, 16'h02BB, 0, 0);
    chk("rt_own", {31'd0, misroute}, 32'd0);
    cyc(0, 0, 16'h0000, 0, 1, 16'h05CC, 0, 0);
    chk("rt_mis", {31'd0, misroute}, 32'd1);
    chk("rt_head0", {16'd0, rx_data}, 32'hFFAA);
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    chk("rt_head1", {16'd0, rx_data}, 32'h02BB);
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    chk("rt_head2", {16'd0, rx_data}, 32'h05CC);
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    chk("rt_empty", {31'd0, rx_valid}, 32'd0);
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1);
    chk("rd_empty_noflag", {31'd0, rx_ovf}, 32'd0);

    // RX overflow and push/read while full
    for (int i = 0; i < 9; i++) cyc(0, 0, 16'h0000, 0, 1, 16'(16'h0200 + i), 0, 0);
    chk("rxf_full", {31'd0, rx_full}, 32'd1);
    chk("rxf_ovf", {31'd0, rx_ovf}, 32'd1);
    chk("rxf_head", {16'd0, rx_data}, 32'h0200);
    cyc(0, 0, 16'h0000, 0, 1, 16'h09FF, 1, 1);
    chk("rxf_mis_drop", {31'd0, misroute}, 32'd1);
    chk("rxf_ovf_clr", {31'd0, rx_ovf}, 32'd0);
    chk("rxf_head1", {16'd0, rx_data}, 32'h0201);
    for (int i = 0; i < 8; i++) cyc(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    chk("rxf_drained", {31'd0, rx_valid}, 32'd0);

    // Reset in the middle of traffic
    for (int i = 0; i < 5; i++) cyc(0, 1, 16'(16'h0A00 + i), 0, 0, 16'h0000, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1, 16'h0201, 0, 0);
    cyc(0, 0, 16'h0000, 1, 1, 16'h0902, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1, 16'hFF03, 0, 0);
    chk("mid_count", {28'd0, tx_count}, 32'd4);
    cyc(1, 1, 16'h0BBB, 0, 1, 16'h0777, 0, 0);
    chk("mid_pndng", {31'd0, pndng}, 32'd0);
    chk("mid_rxvalid", {31'd0, rx_valid}, 32'd0);
    chk("mid_flags", {28'd0, tx_ovf, tx_udf, rx_ovf, misroute}, 32'd0);
    idle();
    chk("mid_dpop", {16'd0, D_pop}, 32'h0000);
    chk("mid_rxdata", {16'd0, rx_data}, 32'h0000);

    idle();
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
